// File: rtl/ram_access_ctrl.sv
// Initiator for a simple dual-port RAM with 1-cycle registered read: single-beat writes,
// incrementing read bursts, and an in-order credited response FIFO with full backpressure.
module ram_access_ctrl #(
    parameter int DATA_WID    = 16,
    parameter int ADDRESS_WID = 4,
    parameter int ADDRESS_MAX = 16,
    parameter int LEN_WID     = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_write,
    input  logic [ADDRESS_WID-1:0] req_addr,
    input  logic [LEN_WID-1:0]     req_len,
    input  logic [DATA_WID-1:0]    req_wdata,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [DATA_WID-1:0]    rsp_rdata,
    output logic [ADDRESS_WID-1:0] ram_address_write,
    output logic [DATA_WID-1:0]    ram_data_write,
    output logic                   ram_write_enable,
    output logic [ADDRESS_WID-1:0] ram_address_read,
    input  logic [DATA_WID-1:0]    ram_data_read,
    output logic                   err_addr
);

    localparam logic [0:0] IDLE     = 1'b0;
    localparam logic [0:0] RD_ISSUE = 1'b1;
    localparam int         FIFO_DEPTH = 4;

    logic [0:0]             state_q, state_d;
    logic                   req_ready_q, req_ready_d;
    logic [ADDRESS_WID-1:0] addr_q, addr_d;
    logic [LEN_WID-1:0]     remain_q, remain_d;
    logic                   pend_q, pend_d;
    logic                   wr_en_q, wr_en_d;
    logic [ADDRESS_WID-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_WID-1:0]    wr_data_q, wr_data_d;
    logic                   err_q, err_d;
    logic [DATA_WID-1:0]    fifo_q [FIFO_DEPTH];
    logic [DATA_WID-1:0]    fifo_d [FIFO_DEPTH];
    logic [1:0]             wr_ptr_q, wr_ptr_d;
    logic [1:0]             rd_ptr_q, rd_ptr_d;
    logic [2:0]             count_q, count_d;

    logic accept;
    logic addr_bad;
    logic credit_ok;
    logic issue;
    logic push;
    logic pop;

    assign accept    = req_valid && req_ready_q;
    assign addr_bad  = 32'(req_addr) >= 32'(ADDRESS_MAX);
    // pend_q is the single beat the RAM has sampled but whose data is not yet in the FIFO.
    assign credit_ok = (32'(count_q) + 32'(pend_q)) < 32'(FIFO_DEPTH);
    assign issue     = (state_q == RD_ISSUE) && credit_ok;
    assign push      = pend_q;
    assign pop       = (count_q != 3'd0) && rsp_ready;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        remain_d  = remain_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        err_d     = 1'b0;
        pend_d    = issue;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (addr_bad) begin
                        err_d = 1'b1;
                    end else if (req_write) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = req_addr;
                        wr_data_d = req_wdata;
                    end else begin
                        state_d  = RD_ISSUE;
                        addr_d   = req_addr;
                        remain_d = req_len;
                    end
                end
            end
            RD_ISSUE: begin
                if (issue) begin
                    addr_d   = (addr_q == ADDRESS_WID'(ADDRESS_MAX - 1)) ? '0
                                                                         : addr_q + ADDRESS_WID'(1);
                    remain_d = remain_q - LEN_WID'(1);
                    if (remain_q == '0) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        req_ready_d = (state_d == IDLE);
    end

    always_comb begin
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            fifo_d[i] = fifo_q[i];
        end
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            fifo_d[wr_ptr_q] = ram_data_read;
            wr_ptr_d         = wr_ptr_q + 2'd1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 2'd1;
        end
        if (push && !pop) begin
            count_d = count_q + 3'd1;
        end else if (!push && pop) begin
            count_d = count_q - 3'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            req_ready_q <= 1'b0;
            addr_q      <= '0;
            remain_q    <= '0;
            pend_q      <= 1'b0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            err_q       <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            req_ready_q <= req_ready_d;
            addr_q      <= addr_d;
            remain_q    <= remain_d;
            pend_q      <= pend_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            err_q       <= err_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
        end
    end

    for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_fifo
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                fifo_q[gi] <= '0;
            end else begin
                fifo_q[gi] <= fifo_d[gi];
            end
        end
    end

    assign req_ready         = req_ready_q;
    assign rsp_valid         = (count_q != 3'd0);
    assign rsp_rdata         = rsp_valid ? fifo_q[rd_ptr_q] : '0;
    assign ram_address_write = wr_addr_q;
    assign ram_data_write    = wr_data_q;
    assign ram_write_enable  = wr_en_q;
    // The RAM samples this at the end of each issue cycle.
    assign ram_address_read  = addr_q;
    assign err_addr          = err_q;

endmodule
